pingpong_img_buf: RTL and testbench

//  Double-buffered (ping-pong) pixel store, 1 write port, NR read ports.
//  The capture/preprocess stage fills one bank while the CNN layer reads a complete frame from the other.

---
 rtl/img_buf_pkg.sv | 18 +
 rtl/pingpong_img_buf_if.sv | 34 +++
 rtl/ram_bank_1wNr.sv | 41 ++++
 rtl/pingpong_img_buf.sv | 138 +++++++++++++
 tb/tb_pingpong_img_buf.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/img_buf_pkg.sv
// Shared constants and types for the ping-pong image buffer.
package img_buf_pkg;

  localparam int unsigned IMG_W   = 28;
  localparam int unsigned IMG_H   = 28;
  localparam int unsigned IMG_PIX = IMG_W * IMG_H;

  localparam int unsigned PIX_DW  = 8;

  typedef logic [PIX_DW-1:0] pixel_t;

  // Which of the two banks a pointer refers to
  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_e;

endpackage

// File: rtl/pingpong_img_buf_if.sv
// Writer/reader bus of the ping-pong image buffer.
// The master is the capture/CNN side; the slave is the buffer itself.
interface pingpong_img_buf_if
  import img_buf_pkg::*;
#(
  parameter int unsigned DW = PIX_DW,
  parameter int unsigned AW = 10,
  parameter int unsigned NR = 2
);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             wr_last;
  logic             wr_ready;
  logic             frm_valid;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_valid;
  logic             rd_done;
  logic             drop_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done,
    input  wr_ready, frm_valid, rd_data, rd_valid, drop_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done,
    output wr_ready, frm_valid, rd_data, rd_valid, drop_err
  );

endinterface

// File: rtl/ram_bank_1wNr.sv
// One pixel bank: one synchronous write port, NR registered read ports.
// Read registers hold their value unless their port is enabled.
module ram_bank_1wNr #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 784,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned NR    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [NR-1:0]    re,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR*DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage write; caller guarantees waddr < DEPTH when we is set
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Per-port registered read; caller guarantees in-range addresses when re is set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (re[i]) begin
          rdata[i*DW +: DW] <= mem[raddr[i*AW +: AW]];
        end
      end
    end
  end

endmodule

// File: rtl/pingpong_img_buf.sv
// Double-buffered pixel store: the writer fills one bank while the reader
// consumes a closed frame from the other. Banks change owner only on
// wr_last (writer closes) and rd_done (reader releases).
module pingpong_img_buf
  import img_buf_pkg::*;
#(
  parameter int unsigned DW    = PIX_DW,
  parameter int unsigned DEPTH = IMG_PIX,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned NR    = 2
) (
  input logic               clk,
  input logic               rst,
  pingpong_img_buf_if.slave bus
);

  // One extra bit so DEPTH is representable even when it is a power of two
  localparam logic [AW:0] DEPTH_X = (AW + 1)'(DEPTH);

  bank_e            wr_sel;
  bank_e            rd_sel;
  logic [1:0]       full_cnt;
  logic             drop_err;

  logic [NR-1:0]    rd_vld;
  logic [NR-1:0]    rd_oob;
  bank_e            rd_src [NR];

  logic             wr_acc;
  logic             wr_close;
  logic             wr_in_range;
  logic             rd_rel;
  logic [NR-1:0]    rd_go;
  logic [NR-1:0]    rd_hit;
  logic [1:0]       bank_we;
  logic [NR-1:0]    bank_re [2];
  logic [NR*DW-1:0] bank_q  [2];
  logic [NR*DW-1:0] rdata;

  assign bus.frm_valid = (full_cnt != 2'd0);
  assign bus.wr_ready  = (full_cnt != 2'd2);
  assign bus.drop_err  = drop_err;
  assign bus.rd_valid  = rd_vld;
  assign bus.rd_data   = rdata;

  assign wr_acc      = bus.wr_en & bus.wr_ready;
  assign wr_close    = wr_acc & bus.wr_last;
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_X);
  assign rd_rel      = bus.rd_done & bus.frm_valid;

  // Decode accepted reads; out-of-range reads complete but skip the RAM
  always_comb begin
    rd_go  = '0;
    rd_hit = '0;
    for (int i = 0; i < NR; i++) begin
      rd_go[i]  = bus.rd_en[i] & bus.frm_valid;
      rd_hit[i] = rd_go[i] & ({1'b0, bus.rd_addr[i*AW +: AW]} < DEPTH_X);
    end
  end

  // Steer write and read strobes to the owning bank
  always_comb begin
    bank_we[0] = wr_acc & wr_in_range & (wr_sel == BANK0);
    bank_we[1] = wr_acc & wr_in_range & (wr_sel == BANK1);
    bank_re[0] = (rd_sel == BANK0) ? rd_hit : '0;
    bank_re[1] = (rd_sel == BANK1) ? rd_hit : '0;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ram_bank_1wNr #(
      .DW   (DW),
      .DEPTH(DEPTH),
      .AW   (AW),
      .NR   (NR)
    ) u_ram (
      .clk  (clk),
      .rst  (rst),
      .we   (bank_we[b]),
      .waddr(bus.wr_addr),
      .wdata(bus.wr_data),
      .re   (bank_re[b]),
      .raddr(bus.rd_addr),
      .rdata(bank_q[b])
    );
  end

  // Bank ownership: writer/reader pointers, closed-bank count, sticky drop flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel   <= BANK0;
      rd_sel   <= BANK0;
      full_cnt <= 2'd0;
      drop_err <= 1'b0;
    end else begin
      if (wr_close) begin
        wr_sel <= bank_e'(~wr_sel);
      end
      if (rd_rel) begin
        rd_sel <= bank_e'(~rd_sel);
      end
      // Close and release in the same cycle cancel out
      full_cnt <= full_cnt + {1'b0, wr_close} - {1'b0, rd_rel};
      if (bus.wr_en && !bus.wr_ready) begin
        drop_err <= 1'b1;
      end
    end
  end

  // Remember per port which bank answered and whether it was out of range
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld <= '0;
      rd_oob <= '0;
      for (int i = 0; i < NR; i++) begin
        rd_src[i] <= BANK0;
      end
    end else begin
      rd_vld <= rd_go;
      for (int i = 0; i < NR; i++) begin
        if (rd_go[i]) begin
          rd_oob[i] <= ~rd_hit[i];
          rd_src[i] <= rd_sel;
        end
      end
    end
  end

  // Output mux; all sources are registers, so data holds while rd_valid=0
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NR; i++) begin
      if (!rd_oob[i]) begin
        rdata[i*DW +: DW] = bank_q[rd_src[i]][i*DW +: DW];
      end
    end
  end

endmodule

// File: tb/tb_pingpong_img_buf.sv
// Directed bench for the ping-pong image buffer.
module tb_pingpong_img_buf;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 784;
  localparam int unsigned AW    = 10;
  localparam int unsigned NR    = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pingpong_img_buf_if #(.DW(DW), .AW(AW), .NR(NR)) bus ();

  pingpong_img_buf #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW),
    .NR   (NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Writes a whole frame with data = addr[7:0] + ofs; optional rd_done on the last pixel
  task automatic fill(input logic [7:0] ofs, input logic done_on_last);
    for (int a = 0; a < DEPTH; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = 8'(a) + ofs;
      bus.wr_last = (a == DEPTH - 1);
      bus.rd_done = done_on_last && (a == DEPTH - 1);
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
    bus.rd_done = 1'b0;
  endtask

  task automatic rd(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                    input logic done);
    bus.rd_en   = en;
    bus.rd_addr = {a1, a0};
    bus.rd_done = done;
    tick();
    bus.rd_en   = 2'b00;
    bus.rd_done = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_last = 1'b0;
    bus.rd_en   = '0;
    bus.rd_addr = '0;
    bus.rd_done = 1'b0;
    rst         = 1'b1;
    #2 rst      = 1'b0;
    #1;

    // Reset state
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
    chk("rst_frm_valid", 32'(bus.frm_valid), 32'h0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("rst_drop_err", 32'(bus.drop_err), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Frame A (data = addr) into bank 0
    fill(8'h00, 1'b0);
    chk("a_frm_valid", 32'(bus.frm_valid), 32'h1);
    chk("a_wr_ready", 32'(bus.wr_ready), 32'h1);
    rd(2'b11, 10'd5, 10'd300, 1'b0);
    chk("a_rd_valid", 32'(bus.rd_valid), 32'h3);
    chk("a_rd_data", 32'(bus.rd_data), 32'h2c05);
    tick();
    chk("hold_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("hold_rd_data", 32'(bus.rd_data), 32'h2c05);

    // Frame B (addr + 0x40) into bank 1: both banks now full
    fill(8'h40, 1'b0);
    chk("full_wr_ready", 32'(bus.wr_ready), 32'h0);
    chk("full_frm_valid", 32'(bus.frm_valid), 32'h1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 10'd5;
    bus.wr_data = 8'hff;
    bus.wr_last = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
    bus.wr_last = 1'b0;
    chk("drop_err_set", 32'(bus.drop_err), 32'h1);
    chk("drop_wr_ready", 32'(bus.wr_ready), 32'h0);
    // Read in the release cycle still sees frame A
    rd(2'b11, 10'd5, 10'd300, 1'b1);
    chk("a_kept_data", 32'(bus.rd_data), 32'h2c05);
    chk("rel_wr_ready", 32'(bus.wr_ready), 32'h1);
    chk("rel_frm_valid", 32'(bus.frm_valid), 32'h1);
    rd(2'b11, 10'd5, 10'd300, 1'b0);
    chk("b_rd_data", 32'(bus.rd_data), 32'h6c45);

    // Frame C (addr + 0x80) closes in the same cycle frame B is released
    fill(8'h80, 1'b1);
    chk("swap_frm_valid", 32'(bus.frm_valid), 32'h1);
    chk("swap_wr_ready", 32'(bus.wr_ready), 32'h1);
    rd(2'b11, 10'd5, 10'd300, 1'b0);
    chk("c_rd_data", 32'(bus.rd_data), 32'hac85);

    // Release C: nothing readable
    rd(2'b00, 10'd0, 10'd0, 1'b1);
    chk("empty_frm_valid", 32'(bus.frm_valid), 32'h0);
    rd(2'b11, 10'd1, 10'd2, 1'b0);
    chk("empty_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("empty_rd_hold", 32'(bus.rd_data), 32'hac85);
    rd(2'b00, 10'd0, 10'd0, 1'b1);
    chk("spurious_done", 32'({bus.frm_valid, bus.wr_ready}), 32'h1);

    // Reset in the middle of a frame
    for (int a = 0; a <= 400; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = 8'h11;
      tick();
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_wr_ready", 32'(bus.wr_ready), 32'h1);
    chk("mid_rst_frm_valid", 32'(bus.frm_valid), 32'h0);
    chk("mid_rst_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("mid_rst_rd_data", 32'(bus.rd_data), 32'h0);
    chk("mid_rst_drop_err", 32'(bus.drop_err), 32'h0);
    bus.wr_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Out-of-range write is dropped silently
    bus.wr_en   = 1'b1;
    bus.wr_addr = 10'd790;
    bus.wr_data = 8'hee;
    tick();
    bus.wr_en = 1'b0;
    chk("oob_wr_drop_err", 32'(bus.drop_err), 32'h0);
    chk("oob_wr_frm_valid", 32'(bus.frm_valid), 32'h0);

    // Fresh frame after reset (addr + 0x33)
    fill(8'h33, 1'b0);
    chk("new_frm_valid", 32'(bus.frm_valid), 32'h1);
    rd(2'b11, 10'd5, 10'd800, 1'b0);
    chk("oob_rd_valid", 32'(bus.rd_valid), 32'h3);
    chk("oob_rd_data", 32'(bus.rd_data), 32'h0038);
    rd(2'b11, 10'd783, 10'd783, 1'b0);
    chk("same_addr_data", 32'(bus.rd_data), 32'h4242);
    rd(2'b10, 10'd0, 10'd400, 1'b0);
    chk("one_port_valid", 32'(bus.rd_valid), 32'h2);
    chk("one_port_data", 32'(bus.rd_data), 32'hc342);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
